// File: rtl/pico_mem_pkg.sv
// Shared definitions for the on-chip SRAM subsystem.
//   - arbiter sequencer state encoding (IDLE -> ISSUE -> RESP)
//   - SRAM word-address width as seen on mem_addr
//   - base word of the 3k-4k control region owned by the MPU / secure loader
package pico_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam int SRAM_ADDR_W     = 22;
    localparam int MPU_REGION_BASE = 768;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two master request ports and the SRAM pin group around
// sram_port_arbiter.
//   slave  : the arbiter view (takes requests + mem_rdata, drives readies and SRAM pins)
//   master : the environment view (masters and SRAM macro)
// Signals:
//   m0_/m1_ valid, addr, wdata, wstrb (request, wstrb == 0 means read)
//   m0_/m1_ ready, rdata             (one-cycle completion pulse and read data)
//   mem_wen, mem_addr, mem_wdata     (SRAM write enables, address, write data)
//   mem_rdata                        (SRAM read data, one cycle after the address)
interface sram_port_arbiter_if
    import pico_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = 32
) ();

    logic                  m0_valid;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [3:0]            m0_wstrb;
    logic                  m0_ready;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_valid;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [3:0]            m1_wstrb;
    logic                  m1_ready;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [3:0]            mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  mem_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output mem_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker (purely combinational).
//   req[1:0] : request lines, bit i for master i
//   last     : index of the master granted most recently
//   gnt_idx  : index of the winner; only meaningful when req != 0
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            // On a tie the master that did not win last time goes first.
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter and sequencer for the single-port on-chip SRAM.
// One access at a time: IDLE (arbitrate + latch) -> ISSUE (drive SRAM)
// -> RESP (one-cycle ready with SRAM read data) -> IDLE.
// Ports:
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : request ports of both masters plus the SRAM pins (slave view)
//   busy   : high in any state other than IDLE
//   grant  : index of the master owning the current access
module sram_port_arbiter
    import pico_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_port_arbiter_if.slave   bus,
    output logic                 busy,
    output logic                 grant
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]            state;
    logic                  last;
    logic                  win;
    logic                  resp;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wen_q;

    rr_arb2 u_arb (
        .req     ({bus.m1_valid, bus.m0_valid}),
        .last    (last),
        .gnt_idx (win)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;  // master 0 wins the first tie
            wen_q   <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.m0_valid || bus.m1_valid) begin
                        grant   <= win;
                        last    <= win;
                        addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
                        wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
                        // Strobes go straight to the pins so the write is
                        // presented during ISSUE and nowhere else.
                        wen_q   <= win ? bus.m1_wstrb : bus.m0_wstrb;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wen_q <= 4'h0;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating with resetn drops the ready pulse when reset lands in RESP,
    // so an abandoned access never completes.
    assign resp = (state == ST_RESP) && resetn;

    assign bus.m0_ready  = resp && !grant;
    assign bus.m1_ready  = resp &&  grant;
    assign bus.m0_rdata  = bus.m0_ready ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = bus.m1_ready ? bus.mem_rdata : '0;

    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy, grant;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy),
        .grant  (grant)
    );

    // SRAM macro model: 1024 words, byte writes, registered read (read-first)
    logic [31:0] sram [1024];
    logic        bd_clr, bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < 1024; i++) sram[i] <= '0;
        end else if (bd_we) begin
            sram[bd_addr] <= bd_data;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wen[b])
                    sram[bus.mem_addr[9:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
        bus.mem_rdata <= sram[bus.mem_addr[9:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic m, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
        if (m) begin
            bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
        end else begin
            bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 4'h0);
        set_req(1'b1, 1'b0, '0, '0, 4'h0);
        tick();
        tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic          mst;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vt[9];

    // One isolated transaction from IDLE, checked cycle by cycle.
    task automatic run_txn(input vec_t v);
        logic [DW-1:0] rd_win, rd_oth;
        logic          rdy_win, rdy_oth;
        set_req(v.mst, 1'b1, v.addr, v.wdata, v.wstrb);
        set_req(!v.mst, 1'b0, '0, '0, 4'h0);
        tick();
        chk("txn_busy_issue", busy, 1);
        chk("txn_grant", grant, v.mst);
        chk("txn_wen_issue", bus.mem_wen, v.wstrb);
        chk("txn_mem_addr", bus.mem_addr, v.addr);
        chk("txn_mem_wdata", bus.mem_wdata, v.wdata);
        chk("txn_no_early_ready", {bus.m0_ready, bus.m1_ready}, 0);
        tick();
        rdy_win = v.mst ? bus.m1_ready : bus.m0_ready;
        rdy_oth = v.mst ? bus.m0_ready : bus.m1_ready;
        rd_win  = v.mst ? bus.m1_rdata : bus.m0_rdata;
        rd_oth  = v.mst ? bus.m0_rdata : bus.m1_rdata;
        chk("txn_ready", rdy_win, 1);
        chk("txn_other_ready", rdy_oth, 0);
        chk("txn_wen_resp", bus.mem_wen, 0);
        chk("txn_other_rdata", rd_oth, 0);
        if (v.wstrb == 4'h0) chk("txn_rdata", rd_win, v.exp_rd);
        set_req(v.mst, 1'b0, '0, '0, 4'h0);
        tick();
        chk("txn_busy_idle", busy, 0);
        chk("txn_ready_idle", {bus.m0_ready, bus.m1_ready}, 0);
    endtask

    // Random-phase reference model state
    logic [31:0]   shadow [1024];
    logic          pv [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [3:0]    ps [2];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int cyc, last_cyc, n;
        logic seen, who;
        bd_clr = 0; bd_we = 0; bd_addr = '0; bd_data = '0;
        bus.mem_rdata = '0;

        // ---------------- reset state ----------------
        do_reset();
        resetn = 1'b0;
        bd_clr = 1;
        tick();
        bd_clr = 0; bd_we = 1; bd_addr = 10'd5; bd_data = 32'hDEADBEEF;
        tick();
        bd_we = 0;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", {bus.m0_ready, bus.m1_ready}, 0);
        chk("rst_mem_wen", bus.mem_wen, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        resetn = 1'b1;

        // ---------------- table-driven transactions ----------------
        vt[0] = '{1'b0, 22'd5,       32'h0,        4'h0,    32'hDEADBEEF};
        vt[1] = '{1'b1, 22'd768,     32'h12345678, 4'hF,    32'h0};
        vt[2] = '{1'b0, 22'd768,     32'h0,        4'h0,    32'h12345678};
        vt[3] = '{1'b0, 22'd100,     32'hAABBCCDD, 4'b0100, 32'h0};
        vt[4] = '{1'b1, 22'd100,     32'h0,        4'h0,    32'h00BB0000};
        vt[5] = '{1'b1, 22'h3FFC07,  32'hCAFEF00D, 4'hF,    32'h0};
        vt[6] = '{1'b0, 22'd7,       32'h0,        4'h0,    32'hCAFEF00D};
        vt[7] = '{1'b0, 22'd768,     32'h0000AAAA, 4'b0011, 32'h0};
        vt[8] = '{1'b1, 22'd768,     32'h0,        4'h0,    32'h1234AAAA};
        for (int i = 0; i < 9; i++) run_txn(vt[i]);

        // ---------------- both valid: alternation from reset ----------------
        do_reset();
        set_req(1'b0, 1'b1, 22'd5, '0, 4'h0);
        set_req(1'b1, 1'b1, 22'd7, '0, 4'h0);
        cyc = 0; last_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0; seen = 0;
            while (!seen && n < 8) begin
                tick(); cyc++; n++;
                seen = bus.m0_ready || bus.m1_ready;
            end
            chk("alt_ready_seen", seen, 1);
            who = bus.m1_ready;
            chk("alt_grant_order", who, g % 2);
            if (g == 0) chk("alt_first_latency", cyc, 2);
            else        chk("alt_spacing", cyc - last_cyc, 3);
            chk("alt_rdata", who ? bus.m1_rdata : bus.m0_rdata,
                (g % 2) ? 32'hCAFEF00D : 32'hDEADBEEF);
            last_cyc = cyc;
        end
        set_req(1'b0, 1'b0, '0, '0, 4'h0);
        set_req(1'b1, 1'b0, '0, '0, 4'h0);
        tick(); tick(); tick();

        // ---------------- reset during ISSUE ----------------
        set_req(1'b0, 1'b1, 22'd5, '0, 4'h0);
        tick();
        chk("rsti_in_issue", busy, 1);
        resetn = 1'b0;
        tick();
        chk("rsti_busy", busy, 0);
        chk("rsti_wen", bus.mem_wen, 0);
        chk("rsti_no_ready", bus.m0_ready, 0);
        set_req(1'b0, 1'b0, '0, '0, 4'h0);
        resetn = 1'b1;
        tick();
        chk("rsti_still_no_ready", bus.m0_ready, 0);
        run_txn(vt[0]);

        // ---------------- reset during RESP ----------------
        set_req(1'b0, 1'b1, 22'd5, '0, 4'h0);
        tick(); tick();
        resetn = 1'b0;
        #1;
        chk("rstr_ready_suppressed", bus.m0_ready, 0);
        set_req(1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        chk("rstr_busy", busy, 0);
        resetn = 1'b1;

        // ---------------- master drops valid during ISSUE ----------------
        set_req(1'b0, 1'b1, 22'd100, '0, 4'h0);
        tick();
        set_req(1'b0, 1'b0, 22'd5, 32'hFFFFFFFF, 4'hF);
        tick();
        chk("drop_ready", bus.m0_ready, 1);
        chk("drop_rdata", bus.m0_rdata, 32'h00BB0000);
        tick();
        chk("drop_idle", busy, 0);
        chk("drop_no_ready", bus.m0_ready, 0);

        // ---------------- randomized against transaction-level model ----------------
        bd_clr = 1; tick(); bd_clr = 0;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        do_reset();
        begin
            int  gedge, next_ok;
            logic mlast, gwin, exp_busy, er0, er1, w;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed, erd;
            logic [3:0]    es;
            gedge = -100; next_ok = 0; mlast = 1'b1; gwin = 0;
            ea = '0; ed = '0; es = '0; erd = '0;
            pv[0] = 0; pv[1] = 0;
            for (int k = 0; k < 600; k++) begin
                exp_busy = (k == gedge) || (k == gedge + 1);
                er0 = (k == gedge + 1) && !gwin;
                er1 = (k == gedge + 1) &&  gwin;
                chk("rnd_busy", busy, exp_busy);
                if (exp_busy) chk("rnd_grant", grant, gwin);
                chk("rnd_wen", bus.mem_wen, (k == gedge) ? es : 4'h0);
                if (k == gedge) chk("rnd_mem_addr", bus.mem_addr, ea);
                if (k == gedge) chk("rnd_mem_wdata", bus.mem_wdata, ed);
                chk("rnd_m0_ready", bus.m0_ready, er0);
                chk("rnd_m1_ready", bus.m1_ready, er1);
                if (!er0) chk("rnd_m0_rdata_zero", bus.m0_rdata, 0);
                if (!er1) chk("rnd_m1_rdata_zero", bus.m1_rdata, 0);
                if ((er0 || er1) && es == 4'h0)
                    chk("rnd_rdata", er1 ? bus.m1_rdata : bus.m0_rdata, erd);
                if (k == gedge + 1) pv[gwin] = 0;
                for (int m = 0; m < 2; m++) begin
                    if (!pv[m] && $urandom_range(0, 2) != 0) begin
                        pv[m] = 1;
                        pa[m] = AW'({$urandom_range(0, 4095), 5'($urandom_range(0, 31))});
                        pd[m] = $urandom;
                        ps[m] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                    end
                end
                set_req(1'b0, pv[0], pa[0], pd[0], ps[0]);
                set_req(1'b1, pv[1], pa[1], pd[1], ps[1]);
                if (k + 1 >= next_ok && (pv[0] || pv[1])) begin
                    w = (pv[0] && pv[1]) ? !mlast : pv[1];
                    mlast = w; gwin = w;
                    gedge = k + 1; next_ok = k + 4;
                    ea = pa[w]; ed = pd[w]; es = ps[w];
                    erd = shadow[ea[9:0]];
                    for (int b = 0; b < 4; b++)
                        if (es[b]) shadow[ea[9:0]][b*8 +: 8] = ed[b*8 +: 8];
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
